// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo datapath slice.
//   DATA_W / TAG_W : machine word and reservation-station tag widths.
//   Tag constants  : NOTAG (0) plus one tag per reservation-station entry.
//   mult_state_e   : multiplier unit FSM states.
package tomasulo_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned TAG_W  = 4;

    localparam logic [3:0] NOTAG  = 4'd0;
    localparam logic [3:0] ADD_1  = 4'd1;
    localparam logic [3:0] ADD_2  = 4'd2;
    localparam logic [3:0] ADD_3  = 4'd3;
    localparam logic [3:0] MULT_1 = 4'd4;
    localparam logic [3:0] MULT_2 = 4'd5;
    localparam logic [3:0] LD_1   = 4'd6;
    localparam logic [3:0] LD_2   = 4'd7;
    localparam logic [3:0] LD_3   = 4'd8;
    localparam logic [3:0] ST_1   = 4'd9;
    localparam logic [3:0] ST_2   = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_exec_unit_if.sv
// Handshake bundle between the multiply reservation station / CDB arbiter and
// the multiplier execution unit.
//   in_valid/in_a/in_b/in_tag : dispatch from the station.
//   unit_ready                : back to the station (multiplier_ready).
//   cdb_req/_tag/_data        : broadcast request to the CDB arbiter.
//   cdb_grant                 : arbiter grant.
//   busy                      : unit is not idle.
// Modport slave is the unit's view; master is the station/arbiter side.
interface mult_exec_unit_if #(
    parameter int unsigned DATA_W = tomasulo_pkg::DATA_W,
    parameter int unsigned TAG_W  = tomasulo_pkg::TAG_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              unit_ready;
    logic              cdb_req;
    logic [TAG_W-1:0]  cdb_req_tag;
    logic [DATA_W-1:0] cdb_req_data;
    logic              cdb_grant;
    logic              busy;

    modport master (
        output in_valid, in_a, in_b, in_tag, cdb_grant,
        input  unit_ready, cdb_req, cdb_req_tag, cdb_req_data, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, cdb_grant,
        output unit_ready, cdb_req, cdb_req_tag, cdb_req_data, busy
    );

endinterface

// File: rtl/mult_step_core.sv
// One combinational shift-add step of the iterative multiplier.
//   acc, a_sh, b_sh, step_cnt : current engine state.
//   acc_nxt                   : acc + a_sh * (low BITS_PER_STEP bits of b_sh).
//   a_nxt / b_nxt             : multiplicand shifted left, multiplier shifted right.
//   cnt_nxt                   : step_cnt + 1.
//   last                      : this step is the final one.
module mult_step_core #(
    parameter int unsigned DATA_W        = 64,
    parameter int unsigned BITS_PER_STEP = 4,
    parameter bit          EARLY_TERM    = 1'b1,
    parameter int unsigned CNT_W         = 4
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] a_sh,
    input  logic [DATA_W-1:0] b_sh,
    input  logic [CNT_W-1:0]  step_cnt,
    output logic [DATA_W-1:0] acc_nxt,
    output logic [DATA_W-1:0] a_nxt,
    output logic [DATA_W-1:0] b_nxt,
    output logic [CNT_W-1:0]  cnt_nxt,
    output logic              last
);
    localparam int unsigned STEPS = DATA_W / BITS_PER_STEP;

    logic [BITS_PER_STEP-1:0] digit;
    logic [DATA_W-1:0]        partial;

    always_comb begin
        digit   = b_sh[BITS_PER_STEP-1:0];
        // Only the low DATA_W bits of the product are ever kept.
        partial = a_sh * DATA_W'(digit);
        acc_nxt = acc + partial;
        a_nxt   = a_sh << BITS_PER_STEP;
        b_nxt   = b_sh >> BITS_PER_STEP;
        cnt_nxt = step_cnt + CNT_W'(1);
        // Early exit once no multiplier bits remain; the step just taken
        // guarantees at least one step even for a zero multiplier.
        last    = (step_cnt == CNT_W'(STEPS - 1)) || (EARLY_TERM && (b_nxt == '0));
    end

endmodule

// File: rtl/mult_exec_unit.sv
// Multiplier functional unit between the multiply reservation station and the
// CDB arbiter. Accepts one tagged operation, computes the low DATA_W bits of
// A*B with an iterative shift-add engine, then holds a CDB request until it is
// granted.
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus        : station/arbiter handshake (mult_exec_unit_if, slave view).
module mult_exec_unit #(
    parameter int unsigned DATA_W        = tomasulo_pkg::DATA_W,
    parameter int unsigned TAG_W         = tomasulo_pkg::TAG_W,
    parameter int unsigned BITS_PER_STEP = 4,
    parameter bit          EARLY_TERM    = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    mult_exec_unit_if.slave bus
);
    import tomasulo_pkg::*;

    localparam int unsigned STEPS = DATA_W / BITS_PER_STEP;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    mult_state_e       state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] a_sh_q, a_sh_d;
    logic [DATA_W-1:0] b_sh_q, b_sh_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;

    logic [DATA_W-1:0] acc_nxt, a_nxt, b_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              last_step;

    mult_step_core #(
        .DATA_W        (DATA_W),
        .BITS_PER_STEP (BITS_PER_STEP),
        .EARLY_TERM    (EARLY_TERM),
        .CNT_W         (CNT_W)
    ) u_step (
        .acc      (acc_q),
        .a_sh     (a_sh_q),
        .b_sh     (b_sh_q),
        .step_cnt (step_cnt_q),
        .acc_nxt  (acc_nxt),
        .a_nxt    (a_nxt),
        .b_nxt    (b_nxt),
        .cnt_nxt  (cnt_nxt),
        .last     (last_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            tag_q      <= '0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            tag_q      <= tag_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        acc_d            = acc_q;
        a_sh_d           = a_sh_q;
        b_sh_d           = b_sh_q;
        tag_d            = tag_q;
        step_cnt_d       = step_cnt_q;
        bus.unit_ready   = 1'b0;
        bus.cdb_req      = 1'b0;
        bus.cdb_req_tag  = '0;
        bus.cdb_req_data = '0;
        bus.busy         = 1'b1;

        unique case (state_q)
            IDLE: begin
                bus.unit_ready = 1'b1;
                bus.busy       = 1'b0;
                // A dispatch carrying NOTAG has nowhere to broadcast; drop it.
                if (bus.in_valid && (bus.in_tag != TAG_W'(NOTAG))) begin
                    acc_d      = '0;
                    a_sh_d     = bus.in_a;
                    b_sh_d     = bus.in_b;
                    tag_d      = bus.in_tag;
                    step_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                acc_d      = acc_nxt;
                a_sh_d     = a_nxt;
                b_sh_d     = b_nxt;
                step_cnt_d = cnt_nxt;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.cdb_req      = 1'b1;
                bus.cdb_req_tag  = tag_q;
                bus.cdb_req_data = acc_q;
                // Station frees its entry on the same edge the result is broadcast.
                bus.unit_ready   = bus.cdb_grant;
                if (bus.cdb_grant) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_exec_unit.sv
module tb_mult_exec_unit;
    import tomasulo_pkg::*;

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
        int          req_edge;
    } exp_t;

    logic clk;
    logic rst_n;
    int   edge_cnt;
    int   checks;
    int   failures;
    exp_t sb_q[$];
    logic req_prev;

    mult_exec_unit_if #(.DATA_W(64), .TAG_W(4)) bus ();
    mult_exec_unit_if #(.DATA_W(64), .TAG_W(4)) bus0 ();

    mult_exec_unit #(
        .DATA_W        (64),
        .TAG_W         (4),
        .BITS_PER_STEP (4),
        .EARLY_TERM    (1'b1)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mult_exec_unit #(
        .DATA_W        (64),
        .TAG_W         (4),
        .BITS_PER_STEP (4),
        .EARLY_TERM    (1'b0)
    ) u_dut_noet (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor on the main DUT.
    initial req_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb_q.size() == 0) begin
                check("idle_no_req", 64'(bus.cdb_req), 64'd0);
            end else if (bus.cdb_req) begin
                if (!req_prev) begin
                    check("req_cycle", 64'(edge_cnt + 1), 64'(sb_q[0].req_edge));
                    check("req_tag_first", 64'(bus.cdb_req_tag), 64'(sb_q[0].tag));
                    check("req_data_first", bus.cdb_req_data, sb_q[0].data);
                end
                if (bus.cdb_grant) begin
                    check("bcast_tag", 64'(bus.cdb_req_tag), 64'(sb_q[0].tag));
                    check("bcast_data", bus.cdb_req_data, sb_q[0].data);
                    check("bcast_ready", 64'(bus.unit_ready), 64'd1);
                    void'(sb_q.pop_front());
                end else begin
                    check("stall_ready", 64'(bus.unit_ready), 64'd0);
                end
            end
            req_prev = bus.cdb_req;
        end else begin
            req_prev = 1'b0;
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag,
                         input int n, input logic [63:0] prod, output int acc_edge);
        int waited;
        exp_t e;
        waited = 0;
        while (bus.busy && waited < 100) begin
            tick();
            waited++;
        end
        check("issue_idle", 64'(bus.busy), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        acc_edge     = edge_cnt + 1;
        e.tag        = tag;
        e.data       = prod;
        e.req_edge   = acc_edge + 1 + n;
        sb_q.push_back(e);
        tick();
        bus.in_valid = 1'b0;
        bus.in_tag   = NOTAG;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((sb_q.size() != 0 || bus.busy) && waited < 300) begin
            tick();
            waited++;
        end
        check("drain_queue", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] ones;
        int t;
        int t2;
        ones = '1;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_tag = NOTAG;
        bus.cdb_grant = 1'b1;
        bus0.in_valid = 1'b0;
        bus0.in_a = '0;
        bus0.in_b = '0;
        bus0.in_tag = NOTAG;
        bus0.cdb_grant = 1'b1;
        tick();
        tick();
        check("rst_ready", 64'(bus.unit_ready), 64'd1);
        check("rst_req", 64'(bus.cdb_req), 64'd0);
        check("rst_tag", 64'(bus.cdb_req_tag), 64'd0);
        check("rst_data", bus.cdb_req_data, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        tick();

        // Simple multiply, grant tied high.
        issue(64'd6, 64'd7, MULT_1, 1, 64'd42, t);
        tick();
        check("simple_req", 64'(bus.cdb_req), 64'd1);
        check("simple_ready", 64'(bus.unit_ready), 64'd1);
        tick();
        check("simple_idle", 64'(bus.busy), 64'd0);

        // Full width, all 16 steps.
        issue(ones, ones, MULT_2, 16, 64'd1, t);
        drain();

        // Arbiter stall.
        bus.cdb_grant = 1'b0;
        issue(64'd3, 64'd5, MULT_1, 1, 64'd15, t);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 64'(bus.cdb_req), 64'd1);
            check("stall_tag", 64'(bus.cdb_req_tag), 64'(MULT_1));
            check("stall_data", bus.cdb_req_data, 64'd15);
            check("stall_ready_tb", 64'(bus.unit_ready), 64'd0);
            if (i == 1) begin
                bus.in_valid = 1'b1;
                bus.in_a     = 64'd1;
                bus.in_b     = 64'd1;
                bus.in_tag   = ADD_1;
            end else if (i == 2) begin
                bus.in_valid = 1'b0;
                bus.in_tag   = NOTAG;
            end
            tick();
        end
        bus.cdb_grant = 1'b1;
        #1;
        check("grant_ready", 64'(bus.unit_ready), 64'd1);
        tick();
        check("grant_idle", 64'(bus.busy), 64'd0);
        check("grant_req_drop", 64'(bus.cdb_req), 64'd0);
        drain();

        // Zero multiplier, early-terminating unit.
        issue(64'd123, 64'd0, MULT_1, 1, 64'd0, t);
        drain();

        // Same stimulus, fixed-latency unit.
        bus0.in_valid = 1'b1;
        bus0.in_a     = 64'd123;
        bus0.in_b     = 64'd0;
        bus0.in_tag   = MULT_1;
        t = edge_cnt + 1;
        tick();
        bus0.in_valid = 1'b0;
        bus0.in_tag   = NOTAG;
        t2 = 0;
        while (!bus0.cdb_req && t2 < 40) begin
            tick();
            t2++;
        end
        check("noet_req", 64'(bus0.cdb_req), 64'd1);
        check("noet_cycle", 64'(edge_cnt + 1), 64'(t + 17));
        check("noet_tag", 64'(bus0.cdb_req_tag), 64'(MULT_1));
        check("noet_data", bus0.cdb_req_data, 64'd0);
        tick();
        check("noet_idle", 64'(bus0.busy), 64'd0);

        // More products: signed operand, multi-step, back-to-back.
        issue(-64'sd3, 64'd5, MULT_2, 1, 64'hFFFF_FFFF_FFFF_FFF1, t);
        issue(64'h1234, 64'h100, MULT_1, 3, 64'h12_3400, t);
        issue(64'd10, 64'd10, MULT_2, 1, 64'd100, t);
        issue(64'd7, 64'h10, MULT_1, 2, 64'd112, t2);
        check("b2b_interval", 64'(t2 - t), 64'd3);
        drain();

        // Reset during BUSY step 5.
        issue(ones, ones, MULT_2, 16, 64'd1, t);
        tick();
        tick();
        tick();
        tick();
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(bus.unit_ready), 64'd1);
        check("mid_rst_req", 64'(bus.cdb_req), 64'd0);
        check("mid_rst_tag", 64'(bus.cdb_req_tag), 64'd0);
        check("mid_rst_data", bus.cdb_req_data, 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        issue(64'd2, 64'd9, MULT_1, 1, 64'd18, t);
        drain();

        // Tag-0 dispatch is ignored, then a real one follows.
        bus.in_valid = 1'b1;
        bus.in_a     = 64'd5;
        bus.in_b     = 64'd5;
        bus.in_tag   = NOTAG;
        tick();
        check("notag_busy", 64'(bus.busy), 64'd0);
        check("notag_ready", 64'(bus.unit_ready), 64'd1);
        check("notag_req", 64'(bus.cdb_req), 64'd0);
        issue(64'h1_0000_0000, 64'h1_0000_0000, MULT_1, 9, 64'd0, t);
        drain();

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
